// File: rtl/axil_ram_arb.sv
// AXI4-Lite slave RAM on a single-ported word array. Reads and writes share the
// array through a round-robin arbiter; the read path can carry one extra register stage.
module axil_ram_arb #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int DEPTH           = 1024,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int SL   = $clog2(STRB_WIDTH);
  localparam int IDXW = ADDR_WIDTH - SL;
  localparam int MEMW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDXW:0] DEPTH_L = (IDXW + 1)'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {GNT_READ = 1'b0, GNT_WRITE = 1'b1} grant_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  aw_hold_q, w_hold_q, ar_hold_q;
  logic [IDXW-1:0]       aw_idx_q, ar_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  grant_e                last_grant_q;

  logic                  wr_go_q, rd_go_q;
  logic [MEMW-1:0]       acc_idx_q;
  logic                  acc_oor_q;
  logic [DATA_WIDTH-1:0] acc_data_q;
  logic [STRB_WIDTH-1:0] acc_strb_q;

  logic                  rp_valid_q, rp_err_q;
  logic [DATA_WIDTH-1:0] rp_data_q;

  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_fire, w_fire, ar_fire;
  logic                  wr_elig, rd_elig, gnt_wr, gnt_rd;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rsp_load, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  unused_ok;

  function automatic logic out_of_range(input logic [IDXW-1:0] idx);
    return {1'b0, idx} >= DEPTH_L;
  endfunction

  assign s_axil_awready = !aw_hold_q && !rst;
  assign s_axil_wready  = !w_hold_q && !rst;
  assign s_axil_arready = !ar_hold_q && !rst;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;

  assign aw_fire = s_axil_awvalid && s_axil_awready;
  assign w_fire  = s_axil_wvalid && s_axil_wready;
  assign ar_fire = s_axil_arvalid && s_axil_arready;

  // A read counts as busy from grant until its response handshake, so rdata never moves under rvalid.
  assign wr_elig = aw_hold_q && w_hold_q && !bvalid_q;
  assign rd_elig = ar_hold_q && !rd_go_q && !rp_valid_q && !rvalid_q;
  assign gnt_wr  = wr_elig && (!rd_elig || last_grant_q == GNT_READ);
  assign gnt_rd  = rd_elig && !gnt_wr;

  always_comb begin
    rd_word = '0;
    if (!acc_oor_q) rd_word = mem[acc_idx_q];
  end

  assign rsp_load = (PIPELINE_OUTPUT != 0) ? rp_valid_q : rd_go_q;
  assign rsp_data = (PIPELINE_OUTPUT != 0) ? rp_data_q  : rd_word;
  assign rsp_err  = (PIPELINE_OUTPUT != 0) ? rp_err_q   : acc_oor_q;

  assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                       s_axil_awaddr[SL-1:0], s_axil_araddr[SL-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_hold_q    <= 1'b0;
      w_hold_q     <= 1'b0;
      ar_hold_q    <= 1'b0;
      aw_idx_q     <= '0;
      ar_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      last_grant_q <= GNT_READ;
      wr_go_q      <= 1'b0;
      rd_go_q      <= 1'b0;
      acc_idx_q    <= '0;
      acc_oor_q    <= 1'b0;
      acc_data_q   <= '0;
      acc_strb_q   <= '0;
      rp_valid_q   <= 1'b0;
      rp_err_q     <= 1'b0;
      rp_data_q    <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
    end else begin
      if (aw_fire) begin
        aw_hold_q <= 1'b1;
        aw_idx_q  <= s_axil_awaddr[ADDR_WIDTH-1:SL];
      end else if (gnt_wr) begin
        aw_hold_q <= 1'b0;
      end

      if (w_fire) begin
        w_hold_q <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end else if (gnt_wr) begin
        w_hold_q <= 1'b0;
      end

      if (ar_fire) begin
        ar_hold_q <= 1'b1;
        ar_idx_q  <= s_axil_araddr[ADDR_WIDTH-1:SL];
      end else if (gnt_rd) begin
        ar_hold_q <= 1'b0;
      end

      wr_go_q <= gnt_wr;
      rd_go_q <= gnt_rd;
      if (gnt_wr) begin
        last_grant_q <= GNT_WRITE;
        acc_idx_q    <= aw_idx_q[MEMW-1:0];
        acc_oor_q    <= out_of_range(aw_idx_q);
        acc_data_q   <= w_data_q;
        acc_strb_q   <= w_strb_q;
      end else if (gnt_rd) begin
        last_grant_q <= GNT_READ;
        acc_idx_q    <= ar_idx_q[MEMW-1:0];
        acc_oor_q    <= out_of_range(ar_idx_q);
      end

      if (wr_go_q) begin
        bvalid_q <= 1'b1;
        bresp_q  <= acc_oor_q ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s_axil_bready) begin
        bvalid_q <= 1'b0;
      end

      rp_valid_q <= (PIPELINE_OUTPUT != 0) && rd_go_q;
      if (rd_go_q) begin
        rp_data_q <= rd_word;
        rp_err_q  <= acc_oor_q;
      end

      if (rsp_load) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rsp_data;
        rresp_q  <= rsp_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Array has no reset; a write caught by rst is dropped along with its response.
  always_ff @(posedge clk) begin
    if (!rst && wr_go_q && !acc_oor_q) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (acc_strb_q[i]) mem[acc_idx_q][8*i +: 8] <= acc_data_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_ram_arb.sv
// Scoreboard bench for axil_ram_arb: stimulus pushes expected responses,
// a negedge monitor pops and compares them on each response handshake.
module tb_axil_ram_arb;

  logic        clk;
  logic        rst;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  int errors = 0;
  int checks = 0;
  logic [1:0]  exp_bq [$];
  logic [33:0] exp_rq [$];

  axil_ram_arb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .DEPTH(1000), .PIPELINE_OUTPUT(0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  always @(negedge clk) begin
    logic [1:0]  eb;
    logic [33:0] er;
    if (!rst && bvalid && bready) begin
      if (exp_bq.size() == 0) timeout("unexpected_bvalid");
      else begin
        eb = exp_bq.pop_front();
        chk("bresp", bresp, eb);
      end
    end
    if (!rst && rvalid && rready) begin
      if (exp_rq.size() == 0) timeout("unexpected_rvalid");
      else begin
        er = exp_rq.pop_front();
        chk("rresp", rresp, er[33:32]);
        chk("rdata", rdata, er[31:0]);
      end
    end
  end

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] e);
    int n;
    bit af, wf;
    exp_bq.push_back(e);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      @(negedge clk);
      af = awvalid && awready;
      wf = wvalid && wready;
      @(posedge clk); #1;
      if (af) awvalid = 1'b0;
      if (wf) wvalid = 1'b0;
      n++;
    end
    if (awvalid || wvalid) begin
      timeout("write_handshake");
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] d, input logic [1:0] e,
                         input bit push);
    int n;
    bit f;
    if (push) exp_rq.push_back({e, d});
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      @(negedge clk);
      f = arvalid && arready;
      @(posedge clk); #1;
      if (f) arvalid = 1'b0;
      n++;
    end
    if (arvalid) begin
      timeout("read_handshake");
      arvalid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_bq.size() != 0 || exp_rq.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_bq.size() != 0 || exp_rq.size() != 0) timeout("wait_idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", awready, 1);
    chk("post_rst_arready", arready, 1);
    chk("post_rst_bvalid", bvalid, 0);
    chk("post_rst_rvalid", rvalid, 0);
    chk("post_rst_rdata", rdata, 0);
    chk("post_rst_resp", {bresp, rresp}, 0);
    @(posedge clk); #1;

    // Test 1: full write then read, with response latency N+2
    do_write(16'h0010, 32'hDEADBEEF, 4'hF, 2'b00);
    @(negedge clk);
    @(negedge clk);
    chk("t1_bvalid_n1", bvalid, 0);
    @(negedge clk);
    chk("t1_bvalid_n2", bvalid, 1);
    wait_idle();
    do_read(16'h0010, 32'hDEADBEEF, 2'b00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_rvalid_n1", rvalid, 0);
    @(negedge clk);
    chk("t1_rvalid_n2", rvalid, 1);
    wait_idle();

    // Test 2: single-byte strobe merge, low address bits ignored
    do_write(16'h0010, 32'h000000AA, 4'b0001, 2'b00);
    wait_idle();
    do_read(16'h0010, 32'hDEADBEAA, 2'b00, 1'b1);
    wait_idle();
    do_read(16'h0013, 32'hDEADBEAA, 2'b00, 1'b1);
    wait_idle();
    do_write(16'h0014, 32'h12345678, 4'b0000, 2'b00);
    wait_idle();

    // Test 3: DEPTH boundary (index 999 valid, 1000 out of range)
    do_write(16'h0F9C, 32'h11223344, 4'hF, 2'b00);
    wait_idle();
    do_write(16'h0FA0, 32'h99887766, 4'hF, 2'b10);
    wait_idle();
    do_read(16'h0FA0, 32'h0, 2'b10, 1'b1);
    wait_idle();
    do_read(16'h0F9C, 32'h11223344, 2'b00, 1'b1);
    wait_idle();

    // Test 4: AW three cycles ahead of W
    exp_bq.push_back(2'b00);
    awaddr = 16'h0020; awvalid = 1'b1;
    @(negedge clk);
    chk("t4_awready_idle", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t4_awready_held", awready, 0);
      chk("t4_wready_open", wready, 1);
      chk("t4_bvalid_none", bvalid, 0);
      @(posedge clk); #1;
    end
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    chk("t4_wready", wready, 1);
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk);
    chk("t4_awready_pre_grant", awready, 0);
    chk("t4_bvalid_m0", bvalid, 0);
    @(negedge clk);
    chk("t4_awready_post_grant", awready, 1);
    chk("t4_bvalid_m1", bvalid, 0);
    @(negedge clk);
    chk("t4_bvalid_m2", bvalid, 1);
    wait_idle();

    // Test 5: simultaneous read/write ties at one address; order shows in read data
    do_write(16'h0040, 32'h0, 4'hF, 2'b00);
    wait_idle();
    do_read(16'h0040, 32'h0, 2'b00, 1'b1);
    wait_idle();
    fork
      do_write(16'h0040, 32'h11111111, 4'hF, 2'b00);
      do_read(16'h0040, 32'h11111111, 2'b00, 1'b1);
    join
    wait_idle();
    do_write(16'h0080, 32'h80808080, 4'hF, 2'b00);
    wait_idle();
    fork
      do_write(16'h0040, 32'h22222222, 4'hF, 2'b00);
      do_read(16'h0040, 32'h11111111, 2'b00, 1'b1);
    join
    wait_idle();
    fork
      do_write(16'h0040, 32'h33333333, 4'hF, 2'b00);
      do_read(16'h0040, 32'h22222222, 2'b00, 1'b1);
    join
    wait_idle();
    fork
      do_write(16'h0040, 32'h44444444, 4'hF, 2'b00);
      do_read(16'h0040, 32'h33333333, 2'b00, 1'b1);
    join
    wait_idle();
    do_read(16'h0040, 32'h44444444, 2'b00, 1'b1);
    wait_idle();
    do_read(16'h0080, 32'h80808080, 2'b00, 1'b1);
    wait_idle();

    // Test 6: write response back-pressure
    bready = 1'b0;
    do_write(16'h0050, 32'hA5A5A5A5, 4'hF, 2'b00);
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) timeout("t6_bvalid");
    @(posedge clk); #1;
    do_write(16'h0054, 32'h5A5A5A5A, 4'hF, 2'b00);
    repeat (10) begin
      @(negedge clk);
      chk("t6_bvalid_hold", bvalid, 1);
      chk("t6_bresp_hold", bresp, 2'b00);
      chk("t6_awready_blocked", awready, 0);
      chk("t6_wready_blocked", wready, 0);
    end
    @(posedge clk); #1 bready = 1'b1;
    wait_idle();
    do_read(16'h0050, 32'hA5A5A5A5, 2'b00, 1'b1);
    wait_idle();
    do_read(16'h0054, 32'h5A5A5A5A, 2'b00, 1'b1);
    wait_idle();

    // Test 7: reset with a read in flight
    do_read(16'h0020, 32'h0, 2'b00, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_arready", arready, 0);
    chk("t7_rst_awready", awready, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t7_rvalid_dropped", rvalid, 0);
    end
    @(posedge clk); #1;
    do_read(16'h0020, 32'hCAFEF00D, 2'b00, 1'b1);
    wait_idle();
    do_read(16'h0010, 32'hDEADBEAA, 2'b00, 1'b1);
    wait_idle();
    do_read(16'h0054, 32'h5A5A5A5A, 2'b00, 1'b1);
    wait_idle();

    chk("final_bq_empty", exp_bq.size(), 0);
    chk("final_rq_empty", exp_rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
